// File: rtl/scoreboard_fifo.sv
// scoreboard_fifo
//   In-order scoreboard sitting between issue and commit. Issue pushes
//   decoded entries into a circular buffer and gets the slot index back as a
//   transaction id. Functional units write results or exceptions back out of
//   order by that id. Commit pops entries strictly in program order, once the
//   head entry's result is valid.
//
//   Ports
//     clk_i, rst_ni    clock, asynchronous active-low reset
//     flush_i          discard every entry; wins over issue/writeback/commit
//     issue_instr_i    decoded entry to push
//     issue_valid_i    issue request
//     issue_ready_o    buffer not full (registered count only)
//     issue_id_o       slot the next issued entry will occupy (tail pointer)
//     wb_valid_i       writeback strobe
//     wb_id_i          slot being written back
//     wb_result_i      64-bit result
//     wb_ex_i          exception raised by the functional unit
//     commit_instr_o   entry at the head pointer
//     commit_valid_o   head entry present and its result valid
//     commit_ack_i     commit consumed the head entry

package ariane_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [7:0]  trans_id;
    logic [3:0]  fu;
    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [63:0] result;
    logic        valid;
    exception_t  ex;
    logic        in_flight;
  } scoreboard_entry_t;

endpackage

module scoreboard_fifo
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = 8,
  localparam int unsigned ID_W = $clog2(NR_ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  scoreboard_entry_t issue_instr_i,
  input  logic              issue_valid_i,
  output logic              issue_ready_o,
  output logic [ID_W-1:0]   issue_id_o,
  input  logic              wb_valid_i,
  input  logic [ID_W-1:0]   wb_id_i,
  input  logic [63:0]       wb_result_i,
  input  exception_t        wb_ex_i,
  output scoreboard_entry_t commit_instr_o,
  output logic              commit_valid_o,
  input  logic              commit_ack_i
);

  localparam logic [ID_W:0] FULL_COUNT = (ID_W+1)'(NR_ENTRIES);

  scoreboard_entry_t mem_q [NR_ENTRIES];
  logic [ID_W-1:0]   head_q;
  logic [ID_W-1:0]   tail_q;
  logic [ID_W:0]     count_q;

  logic              issue_fire;
  logic              wb_fire;
  logic              commit_fire;
  scoreboard_entry_t issue_entry;

  // Commit decisions use the registered head entry, so a writeback landing
  // on the head in the same cycle cannot make commit fire early.
  always_comb begin
    issue_ready_o  = (count_q != FULL_COUNT);
    issue_id_o     = tail_q;
    commit_instr_o = mem_q[head_q];
    commit_valid_o = (count_q != '0) && mem_q[head_q].valid;

    issue_fire  = issue_valid_i && issue_ready_o && !flush_i;
    wb_fire     = wb_valid_i && mem_q[wb_id_i].in_flight && !flush_i;
    commit_fire = commit_ack_i && commit_valid_o && !flush_i;

    issue_entry           = issue_instr_i;
    issue_entry.valid     = 1'b0;
    issue_entry.in_flight = 1'b1;
  end

  // Slots never collide: issue targets a slot that is not in flight (the
  // buffer is not full), and a writeback to a slot committing this cycle is
  // overridden by the commit clear below.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        mem_q[i].valid     <= 1'b0;
        mem_q[i].in_flight <= 1'b0;
      end
    end else begin
      if (issue_fire) begin
        mem_q[tail_q] <= issue_entry;
      end
      if (wb_fire) begin
        mem_q[wb_id_i].result <= wb_result_i;
        mem_q[wb_id_i].valid  <= 1'b1;
        if (wb_ex_i.valid) begin
          mem_q[wb_id_i].ex <= wb_ex_i;
        end
      end
      if (commit_fire) begin
        mem_q[head_q].valid     <= 1'b0;
        mem_q[head_q].in_flight <= 1'b0;
      end
    end
  end

  // Pointers wrap naturally; full vs empty is told apart by count alone.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (issue_fire) begin
        tail_q <= tail_q + 1'b1;
      end
      if (commit_fire) begin
        head_q <= head_q + 1'b1;
      end
      case ({issue_fire, commit_fire})
        2'b10:   count_q <= count_q + (ID_W+1)'(1);
        2'b01:   count_q <= count_q - (ID_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard_fifo.sv
// tb_scoreboard_fifo
//   Drives scoreboard_fifo with directed sequences followed by randomized
//   traffic and compares every cycle against a queue-based model of the
//   in-order scoreboard.

module tb_scoreboard_fifo;
  import ariane_pkg::*;

  localparam int DEPTH = 8;

  logic              clk_i;
  logic              rst_ni;
  logic              flush_i;
  scoreboard_entry_t issue_instr_i;
  logic              issue_valid_i;
  logic              issue_ready_o;
  logic [2:0]        issue_id_o;
  logic              wb_valid_i;
  logic [2:0]        wb_id_i;
  logic [63:0]       wb_result_i;
  exception_t        wb_ex_i;
  scoreboard_entry_t commit_instr_o;
  logic              commit_valid_o;
  logic              commit_ack_i;

  scoreboard_fifo #(.NR_ENTRIES(DEPTH)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .issue_instr_i  (issue_instr_i),
    .issue_valid_i  (issue_valid_i),
    .issue_ready_o  (issue_ready_o),
    .issue_id_o     (issue_id_o),
    .wb_valid_i     (wb_valid_i),
    .wb_id_i        (wb_id_i),
    .wb_result_i    (wb_result_i),
    .wb_ex_i        (wb_ex_i),
    .commit_instr_o (commit_instr_o),
    .commit_valid_o (commit_valid_o),
    .commit_ack_i   (commit_ack_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Reference model: the in-order window as a queue of (id, entry), with the
  // id of the oldest entry tracked separately.
  typedef struct {
    logic [2:0]        id;
    scoreboard_entry_t e;
  } slot_t;

  slot_t model_q[$];
  int    model_head;
  int    n_compared;
  int    n_mismatched;

  task automatic checkOutput(input string tag, input logic [319:0] actual,
                             input logic [319:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  function automatic scoreboard_entry_t rand_instr();
    scoreboard_entry_t e;
    e           = '0;
    e.pc        = {$urandom, $urandom};
    e.trans_id  = 8'($urandom);
    e.fu        = 4'($urandom);
    e.op        = 7'($urandom);
    e.rs1       = 5'($urandom);
    e.rs2       = 5'($urandom);
    e.rd        = 5'($urandom);
    e.result    = {$urandom, $urandom};
    e.valid     = 1'($urandom);
    e.in_flight = 1'($urandom);
    e.ex.valid  = ($urandom_range(0, 7) == 0);
    e.ex.cause  = 64'($urandom_range(0, 15));
    e.ex.tval   = {$urandom, $urandom};
    return e;
  endfunction

  task automatic model_reset();
    model_q.delete();
    model_head = 0;
  endtask

  // Applies one clock edge of scoreboard rules to the model, using the
  // inputs that were present at that edge.
  task automatic model_step();
    int                sz;
    bit                do_issue;
    bit                do_commit;
    logic [2:0]        new_id;
    slot_t             s;
    if (flush_i) begin
      model_reset();
    end else begin
      sz        = model_q.size();
      do_issue  = issue_valid_i && (sz < DEPTH);
      do_commit = commit_ack_i && (sz > 0) && model_q[0].e.valid;
      new_id    = 3'((model_head + sz) % DEPTH);
      if (wb_valid_i) begin
        foreach (model_q[k]) begin
          if (model_q[k].id == wb_id_i) begin
            model_q[k].e.result = wb_result_i;
            model_q[k].e.valid  = 1'b1;
            if (wb_ex_i.valid) model_q[k].e.ex = wb_ex_i;
          end
        end
      end
      if (do_commit) begin
        void'(model_q.pop_front());
        model_head = (model_head + 1) % DEPTH;
      end
      if (do_issue) begin
        s.id          = new_id;
        s.e           = issue_instr_i;
        s.e.valid     = 1'b0;
        s.e.in_flight = 1'b1;
        model_q.push_back(s);
      end
    end
  endtask

  task automatic check_all();
    bit exp_cv;
    exp_cv = (model_q.size() > 0) && model_q[0].e.valid;
    checkOutput("issue_ready", 320'(issue_ready_o), 320'(model_q.size() != DEPTH));
    checkOutput("issue_id", 320'(issue_id_o), 320'((model_head + model_q.size()) % DEPTH));
    checkOutput("commit_valid", 320'(commit_valid_o), 320'(exp_cv));
    if (exp_cv) checkOutput("commit_instr", 320'(commit_instr_o), 320'(model_q[0].e));
  endtask

  // Drives one cycle of inputs, steps the model on the edge and compares
  // shortly after it.
  task automatic applyStimulus(input bit flush, input bit iv,
                               input scoreboard_entry_t instr, input bit wbv,
                               input logic [2:0] wbid, input logic [63:0] res,
                               input exception_t ex, input bit ack);
    flush_i       = flush;
    issue_valid_i = iv;
    issue_instr_i = instr;
    wb_valid_i    = wbv;
    wb_id_i       = wbid;
    wb_result_i   = res;
    wb_ex_i       = ex;
    commit_ack_i  = ack;
    @(posedge clk_i);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_issue_cycle();
    applyStimulus(1'b0, 1'b1, rand_instr(), 1'b0, 3'd0, 64'd0, '0, 1'b0);
  endtask

  task automatic do_wb(input logic [2:0] id, input logic [63:0] res, input bit ack);
    applyStimulus(1'b0, 1'b0, '0, 1'b1, id, res, '0, ack);
  endtask

  task automatic idle_cycles(input int n, input bit ack);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 3'd0, 64'd0, '0, ack);
  endtask

  exception_t ex2;
  logic [2:0] hid;

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    model_reset();
    rst_ni        = 1'b0;
    flush_i       = 1'b0;
    issue_valid_i = 1'b0;
    issue_instr_i = '0;
    wb_valid_i    = 1'b0;
    wb_id_i       = '0;
    wb_result_i   = '0;
    wb_ex_i       = '0;
    commit_ack_i  = 1'b0;

    // Reset values.
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    checkOutput("rst_issue_ready", 320'(issue_ready_o), 320'(1));
    checkOutput("rst_issue_id", 320'(issue_id_o), 320'(0));
    checkOutput("rst_commit_valid", 320'(commit_valid_o), 320'(0));
    checkOutput("rst_commit_instr", 320'(commit_instr_o), 320'(0));
    rst_ni = 1'b1;

    // Fill with 8 entries, 9th must be refused.
    for (int i = 0; i < DEPTH + 1; i++) do_issue_cycle();
    for (int i = 0; i < DEPTH; i++) do_wb(3'(i), 64'(100 + i), 1'b1);
    idle_cycles(3, 1'b1);

    // Out-of-order writeback, in-order commit.
    for (int i = 0; i < 3; i++) do_issue_cycle();
    do_wb(3'd2, 64'hC, 1'b1);
    do_wb(3'd0, 64'hA, 1'b1);
    do_wb(3'd1, 64'hB, 1'b1);
    idle_cycles(4, 1'b1);

    // Full with simultaneous commit and issue.
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 3'd0, 64'd0, '0, 1'b0);
    for (int i = 0; i < DEPTH; i++) do_issue_cycle();
    do_wb(3'd0, 64'h55, 1'b0);
    applyStimulus(1'b0, 1'b1, rand_instr(), 1'b0, 3'd0, 64'd0, '0, 1'b1);
    checkOutput("full_issue_id_after_commit", 320'(issue_id_o), 320'(0));
    do_issue_cycle();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 3'd0, 64'd0, '0, 1'b0);

    // Pointer wrap, then an exception carried through to commit.
    for (int i = 0; i < 10; i++) begin
      hid = issue_id_o;
      do_issue_cycle();
      do_wb(hid, 64'(i), 1'b1);
      idle_cycles(1, 1'b1);
    end
    hid = issue_id_o;
    do_issue_cycle();
    ex2       = '0;
    ex2.valid = 1'b1;
    ex2.cause = 64'd2;
    applyStimulus(1'b0, 1'b0, '0, 1'b1, hid, 64'hBEEF, ex2, 1'b0);
    checkOutput("wrap_ex_valid", 320'(commit_instr_o.ex.valid), 320'(1));
    checkOutput("wrap_ex_cause", 320'(commit_instr_o.ex.cause), 320'(2));
    idle_cycles(1, 1'b1);

    // Flush with concurrent issue, writeback and ack; stale writeback after.
    for (int i = 0; i < 5; i++) do_issue_cycle();
    do_wb(3'(model_head), 64'h77, 1'b0);
    applyStimulus(1'b1, 1'b1, rand_instr(), 1'b1, 3'(model_head + 1), 64'h99, '0, 1'b1);
    do_wb(3'd1, 64'h11, 1'b1);
    do_issue_cycle();
    idle_cycles(2, 1'b1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 3'd0, 64'd0, '0, 1'b0);

    // Asynchronous reset mid-operation with 3 entries.
    for (int i = 0; i < 3; i++) do_issue_cycle();
    do_wb(3'd0, 64'h1, 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    model_reset();
    checkOutput("async_rst_issue_ready", 320'(issue_ready_o), 320'(1));
    checkOutput("async_rst_commit_valid", 320'(commit_valid_o), 320'(0));
    checkOutput("async_rst_issue_id", 320'(issue_id_o), 320'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    check_all();

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      bit         fl;
      bit         iv;
      bit         wbv;
      bit         ack;
      logic [2:0] wid;
      exception_t ex;
      fl  = ($urandom_range(0, 49) == 0);
      iv  = ($urandom_range(0, 2) != 0);
      wbv = ($urandom_range(0, 2) != 0);
      ack = ($urandom_range(0, 3) != 0);
      wid = 3'($urandom);
      if (model_q.size() > 0 && $urandom_range(0, 3) != 0)
        wid = model_q[$urandom_range(0, model_q.size() - 1)].id;
      ex       = '0;
      ex.valid = ($urandom_range(0, 5) == 0);
      ex.cause = 64'($urandom_range(0, 15));
      ex.tval  = {$urandom, $urandom};
      applyStimulus(fl, iv, rand_instr(), wbv, wid, {$urandom, $urandom}, ex, ack);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
